// File: rtl/tstamp_capture.sv
// tstamp_capture
//   Watches the pipelined fractional-second time stream from the GPS clock
//   adder. When the fraction rolls over, it emits a PPS pulse and advances a
//   running seconds count. On an external event it latches a full timestamp
//   (seconds + fraction) and holds it until the consumer acknowledges it.
//
// Ports
//   i_clk      system clock
//   i_reset    synchronous active-high reset
//   i_sync     qualifies i_r, one cycle per new time value
//   i_r        fractional-second time, unsigned, full scale = 1 s
//   i_event    event strobe (already synchronous), one cycle per event
//   i_ack      consumer has read the stamp
//   o_pps      one-cycle pulse per detected second roll-over
//   o_now_sec  running seconds count
//   o_valid    stamp registers hold an unread capture
//   o_sec      captured seconds
//   o_frac     captured fraction
//   o_overrun  sticky: an event was dropped while o_valid was high
module tstamp_capture #(
  parameter int unsigned LGSEC = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_sync,
  input  logic [63:0]      i_r,
  input  logic             i_event,
  input  logic             i_ack,
  output logic             o_pps,
  output logic [LGSEC-1:0] o_now_sec,
  output logic             o_valid,
  output logic [LGSEC-1:0] o_sec,
  output logic [63:0]      o_frac,
  output logic             o_overrun
);

  logic [63:0]      r_last;
  logic             r_primed;

  logic             wrap;
  logic [63:0]      cur_frac;
  logic [LGSEC-1:0] cur_sec;

  // A roll-over is seen as the fraction going backwards between two syncs.
  // Before the first sync there is no reference, so no wrap is possible.
  always_comb begin
    wrap     = i_sync && r_primed && (i_r < r_last);
    cur_frac = i_sync ? i_r : r_last;
    cur_sec  = wrap ? (o_now_sec + LGSEC'(1)) : o_now_sec;
  end

  // Time tracking: last fraction, priming flag, seconds count and PPS.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last    <= '0;
      r_primed  <= 1'b0;
      o_pps     <= 1'b0;
      o_now_sec <= '0;
    end else begin
      o_pps     <= wrap;
      o_now_sec <= cur_sec;
      if (i_sync) begin
        r_last   <= i_r;
        r_primed <= 1'b1;
      end
    end
  end

  // Capture handshake. An ack in the same cycle as an event frees the slot
  // for the new stamp, so that event is accepted rather than dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_sec     <= '0;
      o_frac    <= '0;
      o_overrun <= 1'b0;
    end else if (i_event) begin
      if (!o_valid || i_ack) begin
        o_sec   <= cur_sec;
        o_frac  <= cur_frac;
        o_valid <= 1'b1;
        if (i_ack)
          o_overrun <= 1'b0;
      end else begin
        o_overrun <= 1'b1;
      end
    end else if (i_ack) begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tstamp_capture.sv
module tb_tstamp_capture;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_sync = 1'b0;
  logic [63:0] i_r = '0;
  logic        i_event = 1'b0;
  logic        i_ack = 1'b0;

  logic        o_pps, o_valid, o_overrun;
  logic [31:0] o_now_sec, o_sec;
  logic [63:0] o_frac;

  logic        s_pps, s_valid, s_overrun;
  logic [1:0]  s_now_sec, s_sec;
  logic [63:0] s_frac;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 i_clk = ~i_clk;

  tstamp_capture #(.LGSEC(32)) u_dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_sync(i_sync), .i_r(i_r),
    .i_event(i_event), .i_ack(i_ack), .o_pps(o_pps), .o_now_sec(o_now_sec),
    .o_valid(o_valid), .o_sec(o_sec), .o_frac(o_frac), .o_overrun(o_overrun)
  );

  // Narrow seconds counter so that the all-ones -> 0 roll-over is reached.
  tstamp_capture #(.LGSEC(2)) u_small (
    .i_clk(i_clk), .i_reset(i_reset), .i_sync(i_sync), .i_r(i_r),
    .i_event(i_event), .i_ack(i_ack), .o_pps(s_pps), .o_now_sec(s_now_sec),
    .o_valid(s_valid), .o_sec(s_sec), .o_frac(s_frac), .o_overrun(s_overrun)
  );

  // Reference model: the seconds count is the number of backward steps seen
  // in the synced fraction stream; a stamp is "seconds so far, latest time".
  bit          m_seen;
  logic [63:0] m_prev;
  int unsigned m_rolls;
  bit          m_pps, m_valid, m_over;
  logic [31:0] m_sec;
  logic [63:0] m_frac;

  always @(posedge i_clk) begin
    bit          rolled;
    logic [63:0] t_now;
    if (i_reset) begin
      m_seen = 0; m_prev = '0; m_rolls = 0; m_pps = 0;
      m_valid = 0; m_over = 0; m_sec = '0; m_frac = '0;
    end else begin
      rolled = i_sync && m_seen && (i_r < m_prev);
      t_now  = i_sync ? i_r : m_prev;
      if (rolled) m_rolls = m_rolls + 1;
      m_pps = rolled;
      if (i_sync) begin m_seen = 1; m_prev = i_r; end
      if (i_event && m_valid && !i_ack) begin
        m_over = 1;
      end else if (i_event) begin
        m_valid = 1; m_sec = m_rolls; m_frac = t_now;
        if (i_ack) m_over = 0;
      end else if (i_ack) begin
        m_valid = 0; m_over = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("pps",       64'(o_pps),     64'(m_pps));
      chk("now_sec",   64'(o_now_sec), 64'(m_rolls));
      chk("valid",     64'(o_valid),   64'(m_valid));
      chk("sec",       64'(o_sec),     64'(m_sec));
      chk("frac",      o_frac,         m_frac);
      chk("overrun",   64'(o_overrun), 64'(m_over));
      chk("s_pps",     64'(s_pps),     64'(m_pps));
      chk("s_now_sec", 64'(s_now_sec), 64'(m_rolls % 4));
      chk("s_valid",   64'(s_valid),   64'(m_valid));
      chk("s_sec",     64'(s_sec),     64'(m_sec[1:0]));
      chk("s_frac",    s_frac,         m_frac);
      chk("s_overrun", 64'(s_overrun), 64'(m_over));
    end
  end

  task automatic step(input logic s, input logic [63:0] r, input logic e,
                      input logic a, input logic rs);
    i_sync = s; i_r = r; i_event = e; i_ack = a; i_reset = rs;
    @(posedge i_clk);
    #1;
    i_sync = 1'b0; i_event = 1'b0; i_ack = 1'b0; i_reset = 1'b0;
  endtask

  localparam logic [63:0] F0 = 64'hF000_0000_0000_0000;
  localparam logic [63:0] T1 = 64'h1000_0000_0000_0000;

  initial begin
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    chk_en = 1'b1;
    chk("rst_pps", 64'(o_pps), 64'd0);
    chk("rst_now", 64'(o_now_sec), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_frac", o_frac, 64'd0);

    // Priming sync and a forward step: no roll-over.
    step(1, 64'h4000_0000_0000_0000, 0, 0, 0);
    chk("prime_pps", 64'(o_pps), 64'd0);
    step(1, 64'h8000_0000_0000_0000, 0, 0, 0);
    chk("fwd_pps", 64'(o_pps), 64'd0);
    chk("fwd_now", 64'(o_now_sec), 64'd0);
    step(1, 64'h8000_0000_0000_0000, 0, 0, 0);
    chk("equal_pps", 64'(o_pps), 64'd0);

    // First roll-over.
    step(1, F0, 0, 0, 0);
    step(1, T1, 0, 0, 0);
    chk("wrap_pps", 64'(o_pps), 64'd1);
    chk("wrap_now", 64'(o_now_sec), 64'd1);
    step(0, '0, 0, 0, 0);
    chk("wrap_pps_once", 64'(o_pps), 64'd0);

    // Advance to 5 s with r_last = 0123_4567_89AB_CDEF.
    for (int unsigned k = 0; k < 3; k++) begin
      step(1, F0, 0, 0, 0);
      step(1, T1, 0, 0, 0);
    end
    step(1, F0, 0, 0, 0);
    step(1, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    chk("ev_valid", 64'(o_valid), 64'd1);
    chk("ev_sec", 64'(o_sec), 64'd5);
    chk("ev_frac", o_frac, 64'h0123_4567_89AB_CDEF);
    chk("s_ev_sec", 64'(s_sec), 64'd1);
    step(0, '0, 0, 1, 0);
    chk("ack_valid", 64'(o_valid), 64'd0);
    step(0, '0, 0, 1, 0);
    chk("idle_ack_valid", 64'(o_valid), 64'd0);

    // Reach 7 s, then event on the wrapping sync.
    for (int unsigned k = 0; k < 2; k++) begin
      step(1, F0, 0, 0, 0);
      step(1, T1, 0, 0, 0);
    end
    chk("now7", 64'(o_now_sec), 64'd7);
    step(1, F0, 0, 0, 0);
    step(1, 64'h10, 1, 0, 0);
    chk("co_pps", 64'(o_pps), 64'd1);
    chk("co_sec", 64'(o_sec), 64'd8);
    chk("co_frac", o_frac, 64'h10);
    chk("s_co_now", 64'(s_now_sec), 64'd0);

    // Overrun, then ack clears it.
    step(0, '0, 1, 0, 0);
    chk("ovr_flag", 64'(o_overrun), 64'd1);
    chk("ovr_sec", 64'(o_sec), 64'd8);
    chk("ovr_frac", o_frac, 64'h10);
    step(0, '0, 0, 1, 0);
    chk("ovr_ack_valid", 64'(o_valid), 64'd0);
    chk("ovr_ack_flag", 64'(o_overrun), 64'd0);

    // Event + ack while valid: replaces the stamp.
    step(0, '0, 1, 0, 0);
    step(1, 64'h20, 1, 1, 0);
    chk("evack_valid", 64'(o_valid), 64'd1);
    chk("evack_frac", o_frac, 64'h20);
    chk("evack_over", 64'(o_overrun), 64'd0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 1, 0);
    chk("evack_clr_over", 64'(o_overrun), 64'd0);

    // Reset mid-operation with coincident sync and event.
    step(1, 64'h5, 1, 0, 1);
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_now", 64'(o_now_sec), 64'd0);
    chk("mid_rst_sec", 64'(o_sec), 64'd0);
    step(1, 64'h5, 0, 0, 0);
    chk("post_prime_pps", 64'(o_pps), 64'd0);
    step(1, 64'h1, 0, 0, 0);
    chk("post_wrap_pps", 64'(o_pps), 64'd1);
    chk("post_wrap_now", 64'(o_now_sec), 64'd1);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tstamp_capture.md
Name: tstamp_capture

Overview:
- Consumes the pipelined 64-bit fractional-second time stream (time value plus qualifying sync strobe) produced by the big-adder stage of the GPS clock.
- Detects second roll-over and generates a PPS pulse and a seconds count.
- Latches a full timestamp (seconds plus fraction) when an external event strobe fires, and holds it for the bus side behind a valid/ack handshake.

Parameters:
- LGSEC, 32, width of the whole-seconds counter (and o_sec).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_sync  in  1  qualifies i_r; high for one cycle per new time value
- i_r  in  64  fractional-second time, unsigned, full scale = 1 s
- i_event  in  1  external event strobe, already synchronised to i_clk, one cycle per event
- i_ack  in  1  consumer has read the stamp
- o_pps  out  1  one-cycle pulse per detected second roll-over
- o_now_sec  out  LGSEC  running seconds count
- o_valid  out  1  stamp registers hold an unread capture
- o_sec  out  LGSEC  captured seconds
- o_frac  out  64  captured fraction
- o_overrun  out  1  sticky: an event was dropped while o_valid was high

Behaviour:
- Clock/reset: one clock, i_clk. Reset is synchronous and active-high on i_reset.
- Reset values: o_pps=0, o_now_sec=0, o_valid=0, o_sec=0, o_frac=0, o_overrun=0. Internal r_last=0, r_primed=0.
- Priming: the first i_sync after reset loads r_last<=i_r and sets r_primed. It never produces a wrap.
- Wrap detect: wrap = i_sync && r_primed && (i_r < r_last), unsigned 64-bit compare. Equal values are not a wrap.
- Every i_sync cycle sets r_last<=i_r.
- On wrap: the next cycle has o_pps=1 and o_now_sec=old+1. Latency is 1 clock from the wrapping i_sync. o_now_sec wraps from all-ones to 0 silently. o_pps is 0 on every other cycle.
- Current-time view: cur_frac = i_sync ? i_r : r_last. cur_sec = wrap ? o_now_sec+1 : o_now_sec.
  - An event coincident with a wrapping sync therefore stamps the new second and the post-wrap fraction.
  - Before priming, cur_frac=0 and cur_sec=o_now_sec.
- Capture handshake, in priority order, evaluated each cycle:
  1. i_event && (!o_valid || i_ack): o_sec<=cur_sec, o_frac<=cur_frac, o_valid<=1, o_overrun<=0 if i_ack else unchanged.
  2. i_event && o_valid && !i_ack: stamp unchanged, o_overrun<=1.
  3. !i_event && i_ack: o_valid<=0, o_overrun<=0.
  4. Otherwise: hold.
- o_valid rises 1 clock after i_event. o_sec and o_frac are stable whenever o_valid=1.
- An ack while o_valid=0 is ignored; it has no effect on any output.
- Reset asserted mid-operation: all state returns to reset values on that edge. An event or sync in the same cycle as reset is discarded.
- Implementation: registers only. No combinational path from the inputs to any output.

Test Plan:
- Reset, then i_sync with i_r=64'h4000_0000_0000_0000, then i_r=64'h8000_0000_0000_0000 -> no o_pps, o_now_sec=0, o_valid=0.
- Primed, r_last=64'hF000_0000_0000_0000, then i_sync with i_r=64'h1000_0000_0000_0000 -> o_pps=1 for exactly one cycle, one clock later; o_now_sec 0->1. Repeat from o_now_sec=32'hFFFF_FFFF -> wraps to 0.
- i_event on a non-sync cycle with r_last=64'h0123_4567_89AB_CDEF, o_now_sec=5 -> next cycle o_valid=1, o_sec=5, o_frac=64'h0123_4567_89AB_CDEF.
- i_event on the same cycle as a wrapping sync (i_r=64'h0000_0000_0000_0010, o_now_sec=7) -> o_sec=8, o_frac=64'h10, and o_pps=1 in that same next cycle.
- Second i_event while o_valid=1 and no ack -> stamp unchanged, o_overrun=1. Then i_ack -> o_valid=0 and o_overrun=0 next cycle.
- i_ack together with a new i_event while o_valid=1 -> o_valid stays 1, stamp is the new value, o_overrun stays 0. Assert i_reset in the middle of a sequence -> all outputs 0 next cycle, and the first sync afterwards only primes.
